// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU arbiter slice: opcode and FSM state enums.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd6,
    OP_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } arb_state_t;

  // Codes 3, 4 and 5 have no ALU meaning and are flagged as errors.
  function automatic logic is_legal_op(input logic [2:0] f);
    return (f == OP_AND) || (f == OP_OR) || (f == OP_ADD) ||
           (f == OP_SUB) || (f == OP_SLT);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational WIDTH-bit ALU: AND, OR, ADD, SUB, signed SLT. Carry is discarded.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  // Function decode; unknown codes produce zero.
  always_comb begin
    y = '0;
    case (f)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Round-robin picker: first valid requester after ptr (wrapping), as one-hot and index.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan ptr+1, ptr+2, ... ptr+N_REQ (mod N_REQ); the last candidate is ptr itself,
  // so the most recently served requester has the lowest priority.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU among N_REQ requesters: round-robin accept, one cycle of execute,
// then a held response until the granted requester takes it.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int N_REQ = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*3-1:0]     req_f,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]       rsp_y,
  output logic                   rsp_zero,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [CNT_W-1:0]       ops_done
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] gidx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       f_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic             err_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] ops_q;

  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic [2:0]       f_arr [N_REQ];

  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;

  // Unpack the flat per-requester operand buses.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    assign f_arr[gi] = req_f[gi*3 +: 3];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a    (a_q),
    .b    (b_q),
    .f    (f_q),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Acceptance is only possible while idle, and only for the round-robin winner.
  assign req_ready = (state_q == S_IDLE) ? pick_grant : '0;

  // Arbiter FSM with operand latches, result registers and completion counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDX_W'(N_REQ - 1);
      gidx_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= '0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
      ops_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_any) begin
            a_q     <= a_arr[pick_idx];
            b_q     <= b_arr[pick_idx];
            f_q     <= f_arr[pick_idx];
            gidx_q  <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_legal_op(f_q)) begin
            y_q    <= alu_y;
            zero_q <= alu_zero;
            err_q  <= 1'b0;
          end else begin
            y_q    <= '0;
            zero_q <= 1'b1;
            err_q  <= 1'b1;
          end
          rsp_valid_q <= N_REQ'(1) << gidx_q;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          // Only the granted requester's rsp_ready completes the transaction.
          if (rsp_ready[gidx_q]) begin
            ptr_q       <= gidx_q;
            ops_q       <= ops_q + CNT_W'(1);
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = y_q;
  assign rsp_zero  = zero_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter (WIDTH=32, N_REQ=2, CNT_W=16).
module tb_alu_rr_arbiter;

  localparam int W = 32;
  localparam int N = 2;
  localparam int C = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*3-1:0] req_f;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_y;
  logic           rsp_zero;
  logic           rsp_err;
  logic           busy;
  logic [C-1:0]   ops_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.WIDTH(W), .N_REQ(N), .CNT_W(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_f     (req_f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b);
    req_f[i*3 +: 3] = f;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Check a pending response, print it, and hand it back to its requester.
  task automatic take_rsp(input string tag, input logic [1:0] vexp, input logic [31:0] yexp,
                          input logic zexp, input logic eexp);
    chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(vexp));
    chk({tag, ".rsp_y"},     64'(rsp_y),     64'(yexp));
    chk({tag, ".rsp_zero"},  64'(rsp_zero),  64'(zexp));
    chk({tag, ".rsp_err"},   64'(rsp_err),   64'(eexp));
    $display("txn %s rsp_valid=%b y=%08h zero=%b err=%b ops_done=%0d",
             tag, rsp_valid, rsp_y, rsp_zero, rsp_err, ops_done);
    rsp_ready = vexp;
    step();
    rsp_ready = '0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_f     = '0;
    rsp_ready = '0;
    step();
    step();

    // Reset state
    chk("rst.busy",      64'(busy),      64'd0);
    chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst.rsp_y",     64'(rsp_y),     64'd0);
    chk("rst.rsp_zero",  64'(rsp_zero),  64'd0);
    chk("rst.rsp_err",   64'(rsp_err),   64'd0);
    chk("rst.ops_done",  64'(ops_done),  64'd0);
    reset = 1'b0;

    // 1: single requester, latency
    set_req(0, 3'd2, 32'h000000FF, 32'h00000001);
    req_valid = 2'b01;
    #1;
    chk("t1.req_ready", 64'(req_ready), 64'b01);
    step();
    req_valid = '0;
    chk("t1.exec.req_ready", 64'(req_ready), 64'd0);
    chk("t1.exec.busy",      64'(busy),      64'd1);
    chk("t1.exec.rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    take_rsp("t1", 2'b01, 32'h00000100, 1'b0, 1'b0);
    chk("t1.ops_done", 64'(ops_done), 64'd1);
    chk("t1.busy",     64'(busy),     64'd0);

    // 2: reset, then simultaneous requests -> req0 first, then req1
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t2.ops_done_rst", 64'(ops_done), 64'd0);
    set_req(0, 3'd6, 32'h00000100, 32'h00000001);
    set_req(1, 3'd1, 32'h12345678, 32'h87654321);
    req_valid = 2'b11;
    #1;
    chk("t2.req_ready0", 64'(req_ready), 64'b01);
    step();
    req_valid = 2'b10;
    chk("t2.exec.req_ready", 64'(req_ready), 64'd0);
    step();
    take_rsp("t2a", 2'b01, 32'h000000FF, 1'b0, 1'b0);
    chk("t2.req_ready1", 64'(req_ready), 64'b10);
    step();
    req_valid = '0;
    step();
    take_rsp("t2b", 2'b10, 32'h97755779, 1'b0, 1'b0);
    chk("t2.ops_done", 64'(ops_done), 64'd2);

    // 3: both held valid, alternating grants, one accept per 3 cycles
    set_req(0, 3'd2, 32'h00000001, 32'h00000002);
    set_req(1, 3'd6, 32'h00000005, 32'h00000007);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [1:0]  g;
      logic [31:0] ye;
      g  = (i % 2 == 0) ? 2'b01 : 2'b10;
      ye = (i % 2 == 0) ? 32'h00000003 : 32'hFFFFFFFE;
      #1;
      chk($sformatf("t3.%0d.req_ready", i), 64'(req_ready), 64'(g));
      step();
      chk($sformatf("t3.%0d.exec_ready", i), 64'(req_ready), 64'd0);
      step();
      chk($sformatf("t3.%0d.resp_ready", i), 64'(req_ready), 64'd0);
      take_rsp($sformatf("t3.%0d", i), g, ye, 1'b0, 1'b0);
    end
    req_valid = '0;
    chk("t3.ops_done", 64'(ops_done), 64'd6);

    // 4: response back-pressure; other requester waits
    set_req(1, 3'd0, 32'hFFFFFFFF, 32'h12345678);
    req_valid = 2'b10;
    #1;
    chk("t4.req_ready1", 64'(req_ready), 64'b10);
    step();
    set_req(0, 3'd7, 32'hFFFFFFFF, 32'h00000001);
    req_valid = 2'b01;
    #1;
    chk("t4.exec.req_ready", 64'(req_ready), 64'd0);
    step();
    rsp_ready = 2'b01;  // non-granted requester's ready must be ignored
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4.hold%0d.rsp_valid", i), 64'(rsp_valid), 64'b10);
      chk($sformatf("t4.hold%0d.rsp_y", i),     64'(rsp_y),     64'h12345678);
      chk($sformatf("t4.hold%0d.req_ready", i), 64'(req_ready), 64'd0);
      step();
    end
    take_rsp("t4a", 2'b10, 32'h12345678, 1'b0, 1'b0);
    chk("t4.req_ready0", 64'(req_ready), 64'b01);
    step();
    req_valid = '0;
    step();
    take_rsp("t4b", 2'b01, 32'h00000001, 1'b0, 1'b0);
    chk("t4.ops_done", 64'(ops_done), 64'd8);

    // 5: illegal function, then a legal op that yields zero
    set_req(0, 3'b100, 32'hDEADBEEF, 32'h00000005);
    req_valid = 2'b01;
    #1;
    chk("t5.req_ready", 64'(req_ready), 64'b01);
    step();
    req_valid = '0;
    step();
    take_rsp("t5a", 2'b01, 32'h00000000, 1'b1, 1'b1);
    set_req(0, 3'd6, 32'h00000005, 32'h00000005);
    req_valid = 2'b01;
    step();
    req_valid = '0;
    step();
    take_rsp("t5b", 2'b01, 32'h00000000, 1'b1, 1'b0);
    chk("t5.ops_done", 64'(ops_done), 64'd10);

    // 6: reset during EXEC drops the op; priority restarts at req0
    set_req(1, 3'd2, 32'h00000001, 32'h00000001);
    req_valid = 2'b10;
    #1;
    chk("t6.req_ready1", 64'(req_ready), 64'b10);
    step();
    req_valid = '0;
    chk("t6.exec.busy", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6.busy",      64'(busy),      64'd0);
    chk("t6.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6.ops_done",  64'(ops_done),  64'd0);
    chk("t6.rsp_y",     64'(rsp_y),     64'd0);
    set_req(0, 3'd2, 32'h00000002, 32'h00000003);
    req_valid = 2'b11;
    #1;
    chk("t6.req_ready0", 64'(req_ready), 64'b01);
    step();
    req_valid = '0;
    step();
    take_rsp("t6", 2'b01, 32'h00000005, 1'b0, 1'b0);
    chk("t6.ops_done_after", 64'(ops_done), 64'd1);
    step();
    step();
    chk("t6.idle.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6.idle.busy",      64'(busy),      64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
